// File: rtl/reg_file_pkg.sv
// Shared definitions for the scoreboarded register file: default widths,
// the hardwired zero index and the flattened-port slicing helper.
package reg_file_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;

  // LSB position of port k inside a bus that packs ports of width w side by side
  function automatic int sliceLsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port: the zero-register override, the write-to-read
// bypass, and the ready flag derived from the scoreboard.
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] i_rn,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wn,
  input  logic [DATA_W-1:0] i_d,
  input  logic [DATA_W-1:0] i_regData,
  input  logic              i_pending,
  output logic [DATA_W-1:0] o_q,
  output logic              o_rdy
);

  logic w_isZero;
  logic w_hit;

  assign w_isZero = (i_rn == ADDR_W'(REG_ZERO));
  assign w_hit    = i_we && (i_wn == i_rn);

  // The zero check must come first so a write aimed at index 0 never leaks through
  always_comb begin
    o_q = i_regData;
    if (w_isZero) begin
      o_q = '0;
    end else if (w_hit) begin
      o_q = i_d;
    end
  end

  assign o_rdy = w_isZero | ~i_pending | w_hit;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with NUM_RD bypassed read ports and a per-register
// pending-write scoreboard used by decode for RAW hazard detection.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rn,
  output logic [NUM_RD*DATA_W-1:0] q,
  output logic [NUM_RD-1:0]        rdy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wn,
  input  logic [DATA_W-1:0]        d,
  input  logic                     iss,
  input  logic [ADDR_W-1:0]        iss_rd,
  input  logic                     flush,
  output logic                     pend_any
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_pending;
  logic              w_wrValid;
  logic              w_issValid;

  assign w_wrValid  = we  && (wn     != ADDR_W'(REG_ZERO));
  assign w_issValid = iss && (iss_rd != ADDR_W'(REG_ZERO));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wrValid) begin
      r_regs[wn] <= d;
    end
  end

  // The issue assignment is placed last so a new producer overrides the
  // retiring write's clear when both target the same register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else if (flush) begin
      r_pending <= '0;
    end else begin
      if (w_wrValid) begin
        r_pending[wn] <= 1'b0;
      end
      if (w_issValid) begin
        r_pending[iss_rd] <= 1'b1;
      end
    end
  end

  assign pend_any = |r_pending;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    localparam int RN_LSB = sliceLsb(k, ADDR_W);
    localparam int Q_LSB  = sliceLsb(k, DATA_W);

    logic [ADDR_W-1:0] w_rn;
    assign w_rn = rn[RN_LSB +: ADDR_W];

    reg_file_rd_port #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) u_rdPort (
      .i_rn      (w_rn),
      .i_we      (we),
      .i_wn      (wn),
      .i_d       (d),
      .i_regData (r_regs[w_rn]),
      .i_pending (r_pending[w_rn]),
      .o_q       (q[Q_LSB +: DATA_W]),
      .o_rdy     (rdy[k])
    );
  end

endmodule
